// File: rtl/mux2_stream_pkg.sv
// Shared types for the 2-to-1 packet-aware stream merger.
package mux2_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  function automatic state_e lock_state(input logic src);
    return (src == SRC1) ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/mux2_stream_arb_rr_arb2.sv
// Two-requester round-robin grant; when locked only the locked source may win.
module rr_arb2
  import mux2_stream_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       lock,
  input  logic       lock_id,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (lock) begin
      gnt[lock_id] = req[lock_id];
    end else if (req == 2'b11) begin
      gnt[ptr] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mux2_stream_arb.sv
// 2-to-1 valid/ready stream mux with per-packet locking and a registered output.
module mux2_stream_arb
  import mux2_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              out_sel
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              out_sel_q, out_sel_d;

  logic [1:0]        gnt;
  logic [1:0]        ready;
  logic [1:0]        xfer;
  logic              can_load;
  logic              lock;
  logic              lock_id;
  logic              xfer_any;
  logic              xfer_src;
  logic              xfer_last;
  logic [DATA_W-1:0] xfer_data;

  assign lock    = (state_q != IDLE);
  assign lock_id = (state_q == LOCK1) ? SRC1 : SRC0;

  rr_arb2 u_arb (
    .req     ({in1_valid, in0_valid}),
    .ptr     (ptr_q),
    .lock    (lock),
    .lock_id (lock_id),
    .gnt     (gnt)
  );

  // Readies are forced low while reset is held so nothing is accepted then.
  assign can_load  = !out_valid_q || out_ready;
  assign ready     = gnt & {2{can_load & ~rst}};
  assign in0_ready = ready[0];
  assign in1_ready = ready[1];

  assign xfer      = {in1_valid, in0_valid} & ready;
  assign xfer_any  = |xfer;
  assign xfer_src  = xfer[1] ? SRC1 : SRC0;
  assign xfer_last = xfer[1] ? in1_last : in0_last;
  assign xfer_data = xfer[1] ? in1_data : in0_data;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (xfer_any) begin
          if (xfer_last) ptr_d = ~xfer_src;
          else           state_d = lock_state(xfer_src);
        end
      end
      LOCK0, LOCK1: begin
        if (xfer_any && xfer_last) begin
          state_d = IDLE;
          ptr_d   = ~xfer_src;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (xfer_any) begin
      out_data_d  = xfer_data;
      out_valid_d = 1'b1;
      out_last_d  = xfer_last;
      out_sel_d   = xfer_src;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= SRC0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= SRC0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule
